// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if
//   Bundles the three requester ports and the SDRAM-controller side of the
//   arbiter. Index N of each per-requester vector belongs to requester N.
//   Ports (signals):
//     req/we/addr/din   requester -> arbiter : request level, write flag, address, write data
//     ack/valid/dout    arbiter -> requester : grant pulse, completion pulse, read data
//     sd_addr/sd_din/sd_ce/sd_we/sd_refresh  arbiter -> controller
//     sd_dout           controller -> arbiter : read data
//     busy              arbiter status
//   Modports: slave = arbiter side, master = requesters plus SDRAM controller.
interface sdram_arbiter_if;
   logic [2:0]       req;
   logic [2:0]       we;
   logic [2:0][24:0] addr;
   logic [2:0][7:0]  din;
   logic [2:0]       ack;
   logic [2:0]       valid;
   logic [2:0][7:0]  dout;
   logic [24:0]      sd_addr;
   logic [7:0]       sd_din;
   logic [7:0]       sd_dout;
   logic             sd_ce;
   logic             sd_we;
   logic             sd_refresh;
   logic             busy;

   modport slave (
      input  req, we, addr, din, sd_dout,
      output ack, valid, dout, sd_addr, sd_din, sd_ce, sd_we, sd_refresh, busy
   );

   modport master (
      output req, we, addr, din, sd_dout,
      input  ack, valid, dout, sd_addr, sd_din, sd_ce, sd_we, sd_refresh, busy
   );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Time-slotted arbiter sharing one SDRAM controller between three
//   requesters and a periodic refresh. Each slot lasts SLOT_LEN clocks and is
//   followed by one IDLE decision clock. Refresh beats r0, r0 beats r1/r2,
//   r1 and r2 alternate round-robin.
//   Ports:
//     clk      system clock, rising edge
//     reset_n  asynchronous active-low reset
//     bus      sdram_arbiter_if.slave (requester and controller signals)
module sdram_arbiter #(
   parameter int SLOT_LEN     = 8,
   parameter int DATA_CYC     = 6,
   parameter int REFRESH_CLKS = 500,
   parameter int STARTUP_CLKS = 256
) (
   input  logic           clk,
   input  logic           reset_n,
   sdram_arbiter_if.slave bus
);
   localparam int SC_W = $clog2(SLOT_LEN);
   localparam int SU_W = $clog2(STARTUP_CLKS + 1);
   localparam int RF_W = $clog2(REFRESH_CLKS + 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SLOT_LEN - 1);
   localparam logic [SC_W-1:0] SC_HALF = SC_W'(SLOT_LEN / 2);
   localparam logic [SC_W-1:0] SC_DATA = SC_W'(DATA_CYC);
   localparam logic [SU_W-1:0] SU_LAST = SU_W'(STARTUP_CLKS - 1);
   localparam logic [RF_W-1:0] RF_LAST = RF_W'(REFRESH_CLKS - 1);

   typedef enum logic [1:0] {ST_STARTUP, ST_IDLE, ST_ACCESS, ST_REFRESH} state_t;

   state_t          state_reg, state_next;
   logic [SC_W-1:0] sc_reg, sc_next;
   logic [SU_W-1:0] su_cnt_reg;
   logic [RF_W-1:0] rf_cnt_reg;
   logic            pending_reg;
   logic            rr_reg;        // 0: r1 wins an r1/r2 tie, 1: r2 wins
   logic [1:0]      owner_reg;     // requester owning the current access slot

   logic            grant;
   logic [1:0]      grant_idx;
   logic            refresh_start;
   logic            expire;
   logic            capture;
   logic            ce_next, refresh_next, busy_next;
   logic [2:0]      ack_next, valid_next;

   logic [24:0]     sd_addr_reg;
   logic [7:0]      sd_din_reg;
   logic            sd_we_reg, sd_ce_reg, sd_refresh_reg, busy_reg;
   logic [2:0]      ack_reg, valid_reg;

   assign expire = (rf_cnt_reg == RF_LAST);

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_STARTUP;
         sc_reg    <= '0;
      end else begin
         state_reg <= state_next;
         sc_reg    <= sc_next;
      end
   end

   // Next-state logic, including the IDLE arbitration decision
   always_comb begin
      state_next    = state_reg;
      sc_next       = sc_reg;
      grant         = 1'b0;
      grant_idx     = 2'd0;
      refresh_start = 1'b0;
      case (state_reg)
         ST_STARTUP: begin
            if (su_cnt_reg == SU_LAST) state_next = ST_IDLE;
         end
         ST_IDLE: begin
            sc_next = '0;
            if (pending_reg) begin
               refresh_start = 1'b1;
               state_next    = ST_REFRESH;
            end else if (bus.req[0]) begin
               grant      = 1'b1;
               grant_idx  = 2'd0;
               state_next = ST_ACCESS;
            end else if (bus.req[1] && (!bus.req[2] || !rr_reg)) begin
               grant      = 1'b1;
               grant_idx  = 2'd1;
               state_next = ST_ACCESS;
            end else if (bus.req[2]) begin
               grant      = 1'b1;
               grant_idx  = 2'd2;
               state_next = ST_ACCESS;
            end
         end
         ST_ACCESS, ST_REFRESH: begin
            if (sc_reg == SC_LAST) state_next = ST_IDLE;
            else                   sc_next    = sc_reg + 1'b1;
         end
         default: state_next = ST_STARTUP;
      endcase
   end

   // Output logic: values computed from the next state so that the strobes
   // are registered yet line up with the slot counter.
   always_comb begin
      ce_next      = (state_next == ST_ACCESS)  && (sc_next < SC_HALF);
      refresh_next = (state_next == ST_REFRESH) && (sc_next < SC_HALF);
      busy_next    = (state_next != ST_IDLE);
      capture      = (state_reg == ST_ACCESS) && (sc_reg == SC_DATA);
      ack_next     = '0;
      valid_next   = '0;
      if (grant)   ack_next[grant_idx]  = 1'b1;
      if (capture) valid_next[owner_reg] = 1'b1;
   end

   // Counters, refresh bookkeeping and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         su_cnt_reg     <= '0;
         rf_cnt_reg     <= '0;
         pending_reg    <= 1'b0;
         rr_reg         <= 1'b0;
         owner_reg      <= 2'd0;
         sd_addr_reg    <= '0;
         sd_din_reg     <= '0;
         sd_we_reg      <= 1'b0;
         sd_ce_reg      <= 1'b0;
         sd_refresh_reg <= 1'b0;
         busy_reg       <= 1'b1;
         ack_reg        <= '0;
         valid_reg      <= '0;
      end else begin
         if (state_reg == ST_STARTUP) su_cnt_reg <= su_cnt_reg + 1'b1;
         rf_cnt_reg <= expire ? '0 : rf_cnt_reg + 1'b1;
         // A new expiry wins over the clear, so it is never lost.
         pending_reg <= expire | (pending_reg & ~refresh_start);
         if (grant) begin
            owner_reg   <= grant_idx;
            sd_addr_reg <= bus.addr[grant_idx];
            sd_din_reg  <= bus.din[grant_idx];
            sd_we_reg   <= bus.we[grant_idx];
            if (grant_idx == 2'd1)      rr_reg <= 1'b1;
            else if (grant_idx == 2'd2) rr_reg <= 1'b0;
         end
         sd_ce_reg      <= ce_next;
         sd_refresh_reg <= refresh_next;
         busy_reg       <= busy_next;
         ack_reg        <= ack_next;
         valid_reg      <= valid_next;
      end
   end

   // Per-requester read data holding registers
   for (genvar gi = 0; gi < 3; gi++) begin : g_dout
      logic [7:0] dout_reg;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            dout_reg <= '0;
         else if (capture && !sd_we_reg && (owner_reg == 2'(gi)))
            dout_reg <= bus.sd_dout;
      end
      assign bus.dout[gi] = dout_reg;
   end

   assign bus.ack        = ack_reg;
   assign bus.valid      = valid_reg;
   assign bus.sd_addr    = sd_addr_reg;
   assign bus.sd_din     = sd_din_reg;
   assign bus.sd_we      = sd_we_reg;
   assign bus.sd_ce      = sd_ce_reg;
   assign bus.sd_refresh = sd_refresh_reg;
   assign bus.busy       = busy_reg;
endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter SLOT_LEN, default 8: clocks per SDRAM slot (access or refresh); even, >=6.
REQ-002 Parameter DATA_CYC, default 6: slot clock at which read data is sampled; 1 <= DATA_CYC <= SLOT_LEN-1.
REQ-003 Parameter REFRESH_CLKS, default 500: clocks between refresh requests.
REQ-004 Parameter STARTUP_CLKS, default 256: clocks after reset release during which no slot is issued.
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 rN_req  in  1  requester N (N=0..2) access request, level.
REQ-008 rN_we  in  1  requester N write (1) / read (0).
REQ-009 rN_addr  in  25  requester N byte address.
REQ-010 rN_din  in  8  requester N write data.
REQ-011 rN_ack  out  1  one-clock pulse: request N granted; inputs latched.
REQ-012 rN_dout  out  8  requester N read data, held until N's next valid.
REQ-013 rN_valid  out  1  one-clock pulse: N's access complete (read data valid on rN_dout).
REQ-014 sd_addr  out  25  address to SDRAM controller.
REQ-015 sd_din  out  8  write data to SDRAM controller.
REQ-016 sd_dout  in  8  read data from SDRAM controller.
REQ-017 sd_ce  out  1  access strobe; controller starts a cycle on its rising edge.
REQ-018 sd_we  out  1  write enable for current access.
REQ-019 sd_refresh  out  1  refresh strobe; controller refreshes on its rising edge.
REQ-020 busy  out  1  high while a slot is in progress or startup is pending.

Function
REQ-021 States: STARTUP, IDLE, ACCESS, REFRESH; slot counter sc counts 0..SLOT_LEN-1 in ACCESS/REFRESH.
REQ-022 STARTUP: counts STARTUP_CLKS clocks then enters IDLE; requests are ignored (no ack) meanwhile.
REQ-023 Refresh timer runs from reset release (including STARTUP); every REFRESH_CLKS clocks it sets refresh_pending; pending saturates at 1 (missed expiries are not queued).
REQ-024 IDLE decision each clock, priority: refresh_pending > r0 > round-robin between r1 and r2.
REQ-025 Round-robin pointer starts at r1; after r1 or r2 is granted the pointer moves to the other one; r0 grants and refreshes do not move it.
REQ-026 Grant to N: in the grant clock latch rN_addr/rN_we/rN_din into sd_addr/sd_we/sd_din, pulse rN_ack, enter ACCESS with sc=0.
REQ-027 ACCESS: sd_ce=1 for sc 0..SLOT_LEN/2-1, 0 otherwise; sd_addr/sd_we/sd_din stable for the whole slot.
REQ-028 ACCESS at sc=DATA_CYC: for a read, register sd_dout into rN_dout; rN_valid pulses on the following clock for reads and writes alike.
REQ-029 Refresh start: clear refresh_pending, enter REFRESH with sc=0; sd_refresh=1 for sc 0..SLOT_LEN/2-1, else 0; sd_ce stays 0.
REQ-030 At sc=SLOT_LEN-1 the slot ends; the next clock is an IDLE decision, so back-to-back slots start every SLOT_LEN+1 clocks and sd_ce/sd_refresh always have a low gap before rising again.
REQ-031 sd_ce and sd_refresh are never high in the same clock.
REQ-032 Requester holds rN_addr/we/din stable while rN_req=1 until rN_ack; dropping rN_req before ack withdraws the request with no access.
REQ-033 rN_req still high after rN_ack is a new request, arbitrated normally.
REQ-034 A refresh expiry during ACCESS is serviced in the next IDLE decision, before any requester.
REQ-035 All outputs registered; at most one rN_ack and one rN_valid per clock across N.

Reset
REQ-036 reset_n=0 asynchronously forces: state STARTUP, startup counter and refresh timer reloaded, refresh_pending=0, pointer=r1, sd_ce=sd_refresh=sd_we=0, sd_addr=0, sd_din=0, all rN_ack/rN_valid/rN_dout=0, busy=1.
REQ-037 Reset during ACCESS/REFRESH abandons the slot; no rN_valid is issued for it after reset release.

Verification
REQ-038 Reset release, r1_req=1 from clock 0 -> no ack before clock 256; r1_ack at first IDLE decision after startup; sd_ce high exactly 4 clocks.
REQ-039 r2 read addr 0x0123456, sd_dout driven 0xA5 at sc=6 -> r2_dout=0xA5, r2_valid one pulse at sc=7 clock; r2_dout holds 0xA5 afterwards.
REQ-040 r0, r1, r2 all held high continuously -> grant order r0,r0,...; drop r0 -> r1,r2,r1,r2 alternation; slots spaced 9 clocks.
REQ-041 Refresh timer expires while r0 access active -> next slot is REFRESH (sd_refresh high 4 clocks, sd_ce low), then r0 serviced; refresh count over 5000 clocks = 10 +/-1.
REQ-042 r1_req pulsed high then low before grant (ACCESS busy with r0) -> no r1_ack, no r1 access.
REQ-043 reset_n low at sc=3 of a write -> sd_ce, sd_we low immediately; no r*_valid after release; STARTUP restarts (256 clocks).
